// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state encoding for the register file and its clear sequencer.
package reg_file_pkg;
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: clear-sweep FSM, walks addresses 0..DEPTH-1 one per enabled edge.
module reg_file_clr_seq
   import reg_file_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cen_i,
   input  logic          clr_i,
   output logic          busy_o,
   output logic          clr_en_o,
   output logic [AW-1:0] clr_addr_o
);
   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          last;
   always_comb begin
      last    = cnt_q == AW'(DEPTH - 1);
      state_d = (state_q == IDLE) ? (clr_i ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
      cnt_d   = (state_q == CLEAR && !last) ? cnt_q + 1'b1 : '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (cen_i) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   assign busy_o     = state_q == CLEAR;
   assign clr_en_o   = busy_o;
   assign clr_addr_o = cnt_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, two registered read ports with write-first bypass,
// optional hard-wired zero register and a multi-cycle clear sweep.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cen_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_a_i,
   input  logic [AW-1:0]    rd_addr_b_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] out_a_o,
   output logic [WIDTH-1:0] out_b_o,
   output logic             busy_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic             clr_en, wr_ok;
   logic [AW-1:0]    clr_addr;

   reg_file_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cen_i      (cen_i),
      .clr_i      (clr_i),
      .busy_o     (busy_o),
      .clr_en_o   (clr_en),
      .clr_addr_o (clr_addr)
   );

   // Out-of-range and (optionally) zero addresses neither store nor read back.
   function automatic logic valid(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW + 1)'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
   endfunction

   function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a, input logic [WIDTH-1:0] m,
                                               input logic wok, input logic [AW-1:0] wa,
                                               input logic [WIDTH-1:0] wd);
      return !valid(a) ? '0 : (wok && wa == a) ? wd : m;
   endfunction

   always_comb begin
      wr_ok   = wr_en_i && !busy_o && valid(wr_addr_i);
      mem_d   = mem_q;
      if (clr_en) mem_d[clr_addr] = '0;
      if (wr_ok) mem_d[wr_addr_i] = wr_data_i;
      out_a_d = busy_o ? '0 : rd_val(rd_addr_a_i, mem_q[rd_addr_a_i], wr_ok, wr_addr_i, wr_data_i);
      out_b_d = busy_o ? '0 : rd_val(rd_addr_b_i, mem_q[rd_addr_b_i], wr_ok, wr_addr_i, wr_data_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         mem_q   <= '{default: '0};
         out_a_q <= '0;
         out_b_q <= '0;
      end else if (cen_i) begin
         mem_q   <= mem_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
      end

   assign out_a_o = out_a_q;
   assign out_b_o = out_b_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus random stimulus on DEPTH=8 and DEPTH=6 instances against an array model.
module tb_reg_file;
   logic       clk = 0, rst_n = 0, cen = 0, we = 0, clr = 0;
   logic [2:0] wa = 0, ra = 0, rb = 0;
   logic [7:0] wd = 0;
   logic [7:0] oa8, ob8, oa6, ob6;
   logic       bz8, bz6;
   int checks = 0, errors = 0;

   logic [7:0] mem [2][8];
   logic [7:0] ea [2], eb [2];
   bit         bsy [2];
   int         idx [2];
   int         dep [2] = '{8, 6};

   always #5 clk = ~clk;

   reg_file dut8 (.clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .wr_en_i(we), .wr_addr_i(wa),
                  .wr_data_i(wd), .rd_addr_a_i(ra), .rd_addr_b_i(rb), .clr_i(clr),
                  .out_a_o(oa8), .out_b_o(ob8), .busy_o(bz8));
   reg_file #(.DEPTH(6)) dut6 (.clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .wr_en_i(we), .wr_addr_i(wa),
                  .wr_data_i(wd), .rd_addr_a_i(ra), .rd_addr_b_i(rb), .clr_i(clr),
                  .out_a_o(oa6), .out_b_o(ob6), .busy_o(bz6));

   function automatic bit ok(int a, int d);
      return a != 0 && a < d;
   endfunction

   function automatic logic [7:0] rd(int k, int a);
      if (!ok(a, dep[k])) return 8'h00;
      if (we && wa == a) return wd;
      return mem[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 8; a++) mem[k][a] = 8'h00;
         ea[k] = 0; eb[k] = 0; bsy[k] = 0; idx[k] = 0;
      end
   endtask

   task automatic model_edge();
      if (!cen) return;
      for (int k = 0; k < 2; k++) begin
         if (bsy[k]) begin
            mem[k][idx[k]] = 8'h00;
            ea[k] = 0; eb[k] = 0;
            idx[k]++;
            if (idx[k] == dep[k]) bsy[k] = 0;
         end else begin
            ea[k] = rd(k, ra);
            eb[k] = rd(k, rb);
            if (we && ok(wa, dep[k])) mem[k][wa] = wd;
            if (clr) begin bsy[k] = 1; idx[k] = 0; end
         end
      end
   endtask

   task automatic chk(string tag);
      checks += 6;
      assert (oa8 === ea[0]) else begin errors++; $error("FAIL %s oa8 got %h exp %h", tag, oa8, ea[0]); end
      assert (ob8 === eb[0]) else begin errors++; $error("FAIL %s ob8 got %h exp %h", tag, ob8, eb[0]); end
      assert (bz8 === bsy[0]) else begin errors++; $error("FAIL %s busy8 got %b exp %b", tag, bz8, bsy[0]); end
      assert (oa6 === ea[1]) else begin errors++; $error("FAIL %s oa6 got %h exp %h", tag, oa6, ea[1]); end
      assert (ob6 === eb[1]) else begin errors++; $error("FAIL %s ob6 got %h exp %h", tag, ob6, eb[1]); end
      assert (bz6 === bsy[1]) else begin errors++; $error("FAIL %s busy6 got %b exp %b", tag, bz6, bsy[1]); end
   endtask

   task automatic cycle(string tag);
      @(posedge clk);
      model_edge();
      #1 chk(tag);
   endtask

   task automatic set(logic w, logic [2:0] a, logic [7:0] d, logic [2:0] x, logic [2:0] y, logic c);
      we = w; wa = a; wd = d; ra = x; rb = y; clr = c;
   endtask

   initial begin
      model_reset();
      #2 chk("reset");
      #10 rst_n = 1; cen = 1;
      set(1, 3, 8'hA5, 0, 0, 0); cycle("first_write");
      set(0, 0, 0, 3, 4, 0);     cycle("read_a5");
      assert (oa8 === 8'hA5) else begin errors++; $error("FAIL const_a5 got %h exp a5", oa8); end
      checks++;
      set(1, 5, 8'h3C, 5, 5, 0); cycle("bypass");
      set(1, 0, 8'hFF, 0, 0, 0); cycle("zero_wr");
      set(0, 0, 0, 0, 5, 0);     cycle("zero_rd");
      set(1, 7, 8'h99, 7, 6, 0); cycle("oor_wr_bypass");
      set(0, 0, 0, 7, 6, 0);     cycle("oor_rd");
      for (int a = 1; a < 8; a++) begin set(1, a[2:0], 8'(a * 17), 0, 0, 0); cycle("fill"); end
      set(0, 0, 0, 6, 7, 1); cycle("clr_edge");
      for (int i = 0; i < 8; i++) begin
         set(1, 3'($urandom_range(1, 7)), 8'($urandom), 3'(i), 3, i[0]);
         cycle("sweep");
      end
      assert (bz8 === 1'b0) else begin errors++; $error("FAIL sweep_len got %b exp 0", bz8); end
      checks++;
      for (int a = 0; a < 8; a++) begin set(0, 0, 0, a[2:0], 3'(7 - a), 0); cycle("post_clr"); end
      set(1, 4, 8'h44, 4, 4, 0); cycle("pre_cen");
      cen = 0;
      for (int i = 0; i < 3; i++) begin set(1, 2, 8'(i), 2, 4, i[0]); cycle("cen_off"); end
      cen = 1;
      set(0, 0, 0, 2, 4, 0); cycle("cen_resume");
      for (int i = 0; i < 400; i++) begin
         cen = $urandom_range(0, 9) != 0;
         set($urandom_range(0, 1) == 1, 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
             $urandom_range(0, 39) == 0);
         cycle("random");
      end
      cen = 1;
      set(0, 0, 0, 0, 0, 0);
      while (bsy[0] || bsy[1]) cycle("drain");
      for (int a = 1; a < 8; a++) begin set(1, a[2:0], 8'hF0 | 8'(a), 0, 0, 0); cycle("refill"); end
      set(0, 0, 0, 3, 5, 1); cycle("clr2");
      for (int i = 0; i < 4; i++) begin set(0, 0, 0, 3, 5, 0); cycle("sweep2"); end
      rst_n = 0;
      model_reset();
      #1 chk("rst_mid_sweep");
      #6 rst_n = 1;
      set(1, 2, 8'h5A, 2, 1, 0); cycle("post_rst_write");
      for (int a = 0; a < 8; a++) begin set(0, 0, 0, a[2:0], 3'(7 - a), 0); cycle("post_rst_read"); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
